// File: rtl/uart_trans.sv
// 8N1 UART transmitter with a small circular byte FIFO in front of the shifter.
// All line-side outputs are registered and aligned to the bit periods seen on tx.
module uart_trans #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [2:0]       idx_q, idx_nx;
  logic [7:0]       sh_q, sh_nx;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_nx;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             bit_end;
  logic             wr_ok;
  logic             pop;
  logic             tx_bit;

  assign bit_end = (state_q != IDLE) && (cnt_q == CNT_MAX);
  assign wr_ok   = wr_en && (occ_q != OCC_FULL);

  // Next-state, baud counter, shifter and FIFO occupancy
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    idx_nx   = idx_q;
    sh_nx    = sh_q;
    occ_nx   = occ_q;
    pop      = 1'b0;
    tx_bit   = 1'b1;

    if (state_q != IDLE) begin
      cnt_nx = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        cnt_nx = '0;
        idx_nx = '0;
        if (occ_q != '0) begin
          pop      = 1'b1;
          sh_nx    = mem_q[rd_ptr_q];
          state_nx = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) state_nx = DATA;
      end
      DATA: begin
        tx_bit = sh_q[0];
        if (bit_end) begin
          sh_nx  = {1'b0, sh_q[7:1]};
          idx_nx = idx_q + 3'd1;
          if (idx_q == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (occ_q != '0) begin
            pop      = 1'b1;
            sh_nx    = mem_q[rd_ptr_q];
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    unique case ({wr_ok, pop})
      2'b10:   occ_nx = occ_q + OCC_W'(1);
      2'b01:   occ_nx = occ_q - OCC_W'(1);
      default: occ_nx = occ_q;
    endcase
  end

  // State, pointers and line outputs; outputs follow the state by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tick     <= 1'b0;
      full     <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      idx_q   <= idx_nx;
      sh_q    <= sh_nx;
      occ_q   <= occ_nx;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      tx      <= tx_bit;
      tx_busy <= (state_q != IDLE);
      tx_done <= bit_end && (state_q == STOP);
      tick    <= bit_end;
      full    <= (occ_nx == OCC_FULL);
    end
  end

  // Byte storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: tb/tb_uart_trans.sv
// Randomised and directed bench for uart_trans, checked every cycle against a
// frame-position model of the serial line plus hand-derived frame checks.
module tb_uart_trans;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       full, tx, tx_busy, tx_done, tick;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  uart_trans #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of bytes plus the position inside the frame being sent.
  logic [7:0] mq[$];
  bit         eng_on = 1'b0;
  int         eng_pos = 0;
  logic [7:0] eng_byte = 8'h00;
  bit         m_acc;
  logic exp_tx = 1'b1, exp_tick = 1'b0, exp_done = 1'b0, exp_busy = 1'b0, exp_full = 1'b0;

  function automatic logic line_bit(input logic [7:0] b, input int pos);
    int bi;
    bi = pos / CPB;
    if (bi == 0) return 1'b0;
    if (bi >= 9) return 1'b1;
    return b[bi-1];
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      eng_on = 1'b0; eng_pos = 0; eng_byte = 8'h00;
      exp_tx = 1'b1; exp_tick = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; exp_full = 1'b0;
    end else begin
      m_acc    = wr_en && (mq.size() < DEPTH);
      exp_tx   = eng_on ? line_bit(eng_byte, eng_pos) : 1'b1;
      exp_tick = eng_on && ((eng_pos % CPB) == CPB - 1);
      exp_done = eng_on && (eng_pos == FRAME - 1);
      exp_busy = eng_on;
      if (eng_on && eng_pos != FRAME - 1) begin
        eng_pos++;
      end else if (mq.size() != 0) begin
        eng_byte = mq.pop_front();
        eng_on   = 1'b1;
        eng_pos  = 0;
      end else begin
        eng_on = 1'b0;
      end
      if (m_acc) mq.push_back(din);
      exp_full = (mq.size() == DEPTH);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("tx", 32'(tx), 32'(exp_tx));
      chk("tick", 32'(tick), 32'(exp_tick));
      chk("tx_done", 32'(tx_done), 32'(exp_done));
      chk("tx_busy", 32'(tx_busy), 32'(exp_busy));
      chk("full", 32'(full), 32'(exp_full));
    end
  end

  // Frame capture, starting at the current negedge on the first start-bit sample
  logic [7:0] rb;
  int c_done, c_at, c_tick, c_busy, c_low, c_high;

  task automatic cap();
    rb = 8'h00; c_done = 0; c_at = -1; c_tick = 0; c_busy = 0; c_low = 0; c_high = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k < CPB && tx == 1'b0) c_low++;
      if (k >= FRAME - CPB && tx == 1'b1) c_high++;
      if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2) rb[k / CPB - 1] = tx;
      if (tx_done) begin c_done++; c_at = k; end
      if (tick) c_tick++;
      if (tx_busy) c_busy++;
      @(negedge clk);
    end
  endtask

  task automatic frame_chk(input string nm, input logic [7:0] eb);
    cap();
    chk({nm, "_byte"}, 32'(rb), 32'(eb));
    chk({nm, "_done_cnt"}, 32'(c_done), 1);
    chk({nm, "_done_pos"}, 32'(c_at), 32'(FRAME - 1));
    chk({nm, "_ticks"}, 32'(c_tick), 10);
    chk({nm, "_start_low"}, 32'(c_low), 32'(CPB));
    chk({nm, "_stop_high"}, 32'(c_high), 32'(CPB));
  endtask

  task automatic wait_start(input string nm, input int budget);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      if (tx == 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    chk({nm, "_start_seen"}, 32'(found), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v3 [3];
    logic [7:0] d6 [6];
    int lows, dn, qt;
    v3[0] = 8'h00; v3[1] = 8'hFF; v3[2] = 8'h3C;
    d6[0] = 8'h11; d6[1] = 8'h22; d6[2] = 8'h33; d6[3] = 8'h44; d6[4] = 8'h55; d6[5] = 8'h66;

    #2 rst = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_full", 32'(full), 0);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single 0xA5 frame with write-to-line latency
    wr_en = 1'b1; din = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0; din = 8'h00;
    chk("lat_e0", 32'(tx), 1);
    @(negedge clk);
    chk("lat_e1", 32'(tx), 1);
    @(negedge clk);
    chk("lat_e2", 32'(tx), 0);
    frame_chk("a5", 8'hA5);
    chk("a5_idle_tx", 32'(tx), 1);
    chk("a5_idle_busy", 32'(tx_busy), 0);

    // Three back-to-back frames
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = v3[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_start("b2b", 20);
    qt = 0;
    for (int i = 0; i < 3; i++) begin
      frame_chk("b2b", v3[i]);
      qt += c_busy;
    end
    chk("b2b_busy_cycles", 32'(qt), 32'(3 * FRAME));
    chk("b2b_idle_tx", 32'(tx), 1);

    // Overfill: sixth write dropped, then a write on the pop edge while full
    repeat (5) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("full_before_6th", 32'(full), 1);
      wr_en = 1'b1; din = d6[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("ovf_f1_in_start", 32'(tx), 0);
    rb = 8'h00;
    for (int k = 3; k < FRAME; k++) begin
      if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2) rb[k / CPB - 1] = tx;
      if (k == FRAME - 2) begin
        chk("full_pre_pop", 32'(full), 1);
        wr_en = 1'b1; din = 8'hEE;
      end
      if (k == FRAME - 1) begin
        wr_en = 1'b0;
        chk("pop_edge_done", 32'(tx_done), 1);
        chk("full_after_pop", 32'(full), 0);
      end
      @(negedge clk);
    end
    chk("ovf_f1_byte", 32'(rb), 32'(d6[0]));
    for (int i = 1; i < 5; i++) frame_chk("ovf", d6[i]);
    lows = 0; dn = 0;
    for (int k = 0; k < 300; k++) begin
      if (tx == 1'b0) lows++;
      if (tx_done) dn++;
      @(negedge clk);
    end
    chk("ovf_no_sixth_low", 32'(lows), 0);
    chk("ovf_no_sixth_done", 32'(dn), 0);

    // Reset during data bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; din = 8'h55 + 8'(i * 17);
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    chk("mid_bit3_tx", 32'(tx), 0);
    chk("mid_bit3_busy", 32'(tx_busy), 1);
    #3 rst = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 1);
    chk("abort_busy", 32'(tx_busy), 0);
    chk("abort_full", 32'(full), 0);
    chk("abort_done", 32'(tx_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    qt = 0;
    for (int k = 0; k < 100; k++) begin
      if (tx == 1'b1 && tx_busy == 1'b0) qt++;
      @(negedge clk);
    end
    chk("post_rst_quiet", 32'(qt), 100);

    // din scrambled every cycle after writing 0x5A
    wr_en = 1'b1; din = 8'h5A;
    @(negedge clk);
    wr_en = 1'b0;
    rb = 8'h00;
    for (int k = 1; k < 3 + FRAME; k++) begin
      din = 8'($urandom);
      if (k >= 3 + CPB && k < 3 + 9 * CPB && ((k - 3) % CPB) == CPB / 2)
        rb[(k - 3) / CPB - 1] = tx;
      @(negedge clk);
    end
    chk("scramble_byte", 32'(rb), 32'h5A);

    // Random traffic with one asynchronous reset in the middle
    for (int k = 0; k < 6000; k++) begin
      wr_en = ($urandom_range(0, 29) == 0);
      din = 8'($urandom);
      if (k == 3000) begin
        wr_en = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    wr_en = 1'b0;
    repeat (FRAME * (DEPTH + 1) + 10) @(negedge clk);
    chk("drain_tx", 32'(tx), 1);
    chk("drain_busy", 32'(tx_busy), 0);
    chk("drain_full", 32'(full), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
